score_keeper: RTL

- Producer side of the scoring interface consumed by state_machine.
- Turns raw wall-miss indications from the ball/physics logic into per-player score counters (p1, p2) and a one-cycle score pulse.
- Enforces a post-point serve hold and declares the winner.
- Outputs drive state_machine and the 7-segment/VGA score display; it reads back state_machine's cur_state to gate counting and clear scores on game start.

---
 rtl/score_keeper_pkg.sv | 26 ++
 rtl/score_keeper_edge_detect.sv | 31 +++
 rtl/score_keeper.sv | 121 ++++++++++++
 3 files changed

// File: rtl/score_keeper_pkg.sv
// score_keeper_pkg
// Shared encodings for the scoring slice. The game-state codes must match
// what state_machine drives on cur_state, and the winner codes are what the
// display and state_machine decode from score_keeper's winner output.
//
// Contents:
//   game_state_e : ST_IDLE=00, ST_PLAY=01, ST_OVER=10 (11 behaves as idle)
//   winner_e     : WIN_NONE=00, WIN_P1=01, WIN_P2=10
package score_keeper_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_OVER = 2'b10
   } game_state_e;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10
   } winner_e;

   // Width of each player's score counter; WIN_SCORE has to fit in it.
   localparam int SCORE_W = 3;

endpackage

// File: rtl/score_keeper_edge_detect.sv
// edge_detect
// Turns a level signal into a one-cycle rise indication. The input is
// registered once and the rise is the combinational "high now, low last
// cycle" term, so a level held high for many cycles yields a single rise.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, clears the history register
//   in   : level input
//   rise : high in the first cycle that in is sampled high
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic rise
);

   logic in_q;

   // History register holding last cycle's value of the input.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_q <= 1'b0;
      end else begin
         in_q <= in;
      end
   end

   assign rise = in & ~in_q;

endmodule

// File: rtl/score_keeper.sv
// score_keeper
// Producer side of the scoring interface. Converts wall-miss levels from the
// ball logic into per-player scores, a one-cycle score pulse, a post-point
// serve hold and a sticky winner code. It watches state_machine's cur_state
// so that points only count during PLAY and scores clear when a game starts.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   cur_state  : game state from state_machine (IDLE/PLAY/OVER, 11 = idle)
//   miss_left  : ball past left wall (point to player 2), level
//   miss_right : ball past right wall (point to player 1), level
//   p1, p2     : player scores
//   score      : one-cycle pulse per awarded point
//   serve_hold : high for HOLD_CYCLES cycles after each point
//   winner     : 00 none, 01 player 1, 10 player 2; sticky until game start
module score_keeper
   import score_keeper_pkg::*;
#(
   parameter int WIN_SCORE   = 5,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int HOLD_W      = 26
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         cur_state,
   input  logic               miss_left,
   input  logic               miss_right,
   output logic [SCORE_W-1:0] p1,
   output logic [SCORE_W-1:0] p2,
   output logic               score,
   output logic               serve_hold,
   output logic [1:0]         winner
);

   localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
   localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

   logic               rise_left;
   logic               rise_right;
   logic [1:0]         prev_state;
   logic [HOLD_W-1:0]  hold_cnt;
   logic               in_play;
   logic               start_clear;
   logic               eligible;
   logic               award_p1;
   logic               award_p2;
   logic [SCORE_W-1:0] p1_next;
   logic [SCORE_W-1:0] p2_next;

   edge_detect u_edge_left (
      .clk  (clk),
      .rst  (rst),
      .in   (miss_left),
      .rise (rise_left)
   );

   edge_detect u_edge_right (
      .clk  (clk),
      .rst  (rst),
      .in   (miss_right),
      .rise (rise_right)
   );

   // The hold counter counts remaining frozen cycles, so serve_hold is simply
   // "counter not yet exhausted" and lines up with the score pulse.
   assign serve_hold = (hold_cnt != '0);

   // Point qualification. A game start takes priority over any rise in the
   // same cycle, and a simultaneous left/right rise is treated as ambiguous
   // and dropped entirely.
   always_comb begin
      in_play     = (cur_state == ST_PLAY);
      start_clear = in_play && (prev_state != ST_PLAY);
      eligible    = in_play && !serve_hold && (winner == WIN_NONE) && !start_clear;
      award_p1    = eligible && rise_right && !rise_left;
      award_p2    = eligible && rise_left && !rise_right;
      p1_next     = p1 + 1'b1;
      p2_next     = p2 + 1'b1;
   end

   // Score, hold and win state. Scores and winner are left untouched outside
   // PLAY so the display keeps showing the final result; only the hold is
   // dropped when play stops.
   always_ff @(posedge clk) begin
      if (rst) begin
         p1         <= '0;
         p2         <= '0;
         score      <= 1'b0;
         winner     <= WIN_NONE;
         hold_cnt   <= '0;
         prev_state <= ST_IDLE;
      end else begin
         prev_state <= cur_state;
         score      <= award_p1 || award_p2;
         if (start_clear) begin
            p1       <= '0;
            p2       <= '0;
            winner   <= WIN_NONE;
            hold_cnt <= '0;
         end else if (!in_play) begin
            hold_cnt <= '0;
         end else if (award_p1) begin
            p1       <= p1_next;
            hold_cnt <= HOLD_LOAD;
            if (p1_next == WIN_VAL) begin
               winner <= WIN_P1;
            end
         end else if (award_p2) begin
            p2       <= p2_next;
            hold_cnt <= HOLD_LOAD;
            if (p2_next == WIN_VAL) begin
               winner <= WIN_P2;
            end
         end else if (serve_hold) begin
            hold_cnt <= hold_cnt - 1'b1;
         end
      end
   end

endmodule
